// File: rtl/start_fifo_srl_ctrl.sv
// Start-token FIFO controller around an SRL shift array; 1-cycle push-to-visible latency, registered full/empty flags.
// Optional sticky overflow/underflow error outputs when START_FIFO_ERR_EN is defined.
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef START_FIFO_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  udf_err
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] srl_q [DEPTH];
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  init_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  push, pop;

    assign push = if_write & if_write_ce & full_n_q;
    assign pop  = if_read  & if_read_ce  & empty_n_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // During the post-reset init cycle count is 0, so full_n simply opens up.
    assign full_n_d  = init_q ? 1'b1 : (count_d != DEPTH_C);
    assign empty_n_d = (count_d != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            full_n_q  <= 1'b0;
            empty_n_q <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            init_q    <= 1'b0;
        end
    end

    // Storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            srl_q[0] <= if_din;
            for (int i = DEPTH - 1; i > 0; i--) begin
                srl_q[i] <= srl_q[i-1];
            end
        end
    end

    assign addr = ADDR_WIDTH'(count_q - 1'b1);

    always_comb begin
        if_dout = '0;
        if ({1'b0, addr} < DEPTH_C) begin
            if_dout = srl_q[addr];
        end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;

`ifdef START_FIFO_ERR_EN
    logic ovf_err_q, udf_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            if (if_write & if_write_ce & ~full_n_q & ~init_q) begin
                ovf_err_q <= 1'b1;
            end
            if (if_read & if_read_ce & ~empty_n_q) begin
                udf_err_q <= 1'b1;
            end
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Directed plus randomized bench for start_fifo_srl_ctrl against a queue-based reference model.
// Error-flag checks are active only when START_FIFO_ERR_EN is defined.
module tb_start_fifo_srl_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_full_n;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
`ifdef START_FIFO_ERR_EN
    logic          ovf_err;
    logic          udf_err;
`endif

    start_fifo_srl_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_full_n   (if_full_n),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .if_empty_n  (if_empty_n)
`ifdef START_FIFO_ERR_EN
        ,
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // Reference model: an ordered queue of tokens plus the init flag.
    logic [DW-1:0] mq[$];
    logic          m_init;
    logic          m_ovf, m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_full_n();
        return !m_init && (mq.size() != DEPTH);
    endfunction

    function automatic logic m_empty_n();
        return !m_init && (mq.size() != 0);
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".empty_n"}, 32'(if_empty_n), 32'(m_empty_n()));
        check({tag, ".full_n"},  32'(if_full_n),  32'(m_full_n()));
        if (mq.size() != 0) check({tag, ".dout"}, 32'(if_dout), 32'(mq[0]));
`ifdef START_FIFO_ERR_EN
        check({tag, ".ovf"}, 32'(ovf_err), 32'(m_ovf));
        check({tag, ".udf"}, 32'(udf_err), 32'(m_udf));
`endif
    endtask

    // One clock cycle with the given request pattern; checks after the edge.
    task automatic step(input string tag, input logic w, input logic wce,
                        input logic r, input logic rce, input logic [DW-1:0] d);
        logic psh, pp;
        if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce; if_din = d;
        psh = w && wce && m_full_n();
        pp  = r && rce && m_empty_n();
        if (w && wce && !m_full_n() && !m_init) m_ovf = 1'b1;
        if (r && rce && !m_empty_n()) m_udf = 1'b1;
        @(posedge clk);
        #1;
        if (pp)  void'(mq.pop_front());
        if (psh) mq.push_back(d);
        m_init = 1'b0;
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
        check_state(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_init = 1'b1;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    initial begin
        model_reset();

        // Power-on reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst.empty_n", 32'(if_empty_n), 32'h0);
        check("rst.full_n",  32'(if_full_n),  32'h0);
        reset_n = 1'b1;
        #1;
        check("rel.full_n_pre_edge", 32'(if_full_n), 32'h0);
        step("init", 0, 0, 0, 0, 8'h00);

        // Fill then drain.
        step("fill1", 1, 1, 0, 0, 8'h11);
        step("fill2", 1, 1, 0, 0, 8'h22);
        step("fill3", 1, 1, 0, 0, 8'h33);
        step("fill4", 1, 1, 0, 0, 8'h44);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 1, 1, 8'h00);
        step("rd_empty", 0, 0, 1, 1, 8'h00);

        // Concurrent push+pop at count=2.
        step("cc_a0", 1, 1, 0, 0, 8'hA0);
        step("cc_b0", 1, 1, 0, 0, 8'hB0);
        step("cc_both", 1, 1, 1, 1, 8'hC0);
        check("cc.dout_b0", 32'(if_dout), 32'hB0);
        step("cc_pop1", 0, 0, 1, 1, 8'h00);
        check("cc.dout_c0", 32'(if_dout), 32'hC0);
        step("cc_pop2", 0, 0, 1, 1, 8'h00);

        // Push+pop on empty: only the push lands.
        step("both_empty", 1, 1, 1, 1, 8'h5A);
        step("both_empty_pop", 0, 0, 1, 1, 8'h00);

        // Overflow: fill, write 0xEE while full, push+pop while full, drain.
        for (int i = 0; i < 4; i++) step("of_fill", 1, 1, 0, 0, 8'(8'h61 + i));
        step("of_write", 1, 1, 0, 0, 8'hEE);
        step("of_both_full", 1, 1, 1, 1, 8'hEF);
        for (int i = 0; i < 4; i++) step("of_drain", 0, 0, 1, 1, 8'h00);

        // Clock-enable gating.
        for (int i = 0; i < 5; i++) step("gate_w", 1, 0, 0, 0, 8'h77);
        step("gate_fill", 1, 1, 0, 0, 8'h91);
        step("gate_fill", 1, 1, 0, 0, 8'h92);
        for (int i = 0; i < 3; i++) step("gate_r", 0, 0, 1, 0, 8'h00);

        // Mid-operation asynchronous reset with 3 tokens queued.
        step("mid_fill", 1, 1, 0, 0, 8'h93);
        reset_n = 1'b0;
        #1;
        check("mid.empty_n_async", 32'(if_empty_n), 32'h0);
        check("mid.full_n_async",  32'(if_full_n),  32'h0);
        model_reset();
        #1;
        reset_n = 1'b1;
        step("mid_after", 0, 0, 0, 0, 8'h00);
        step("mid_rd_empty", 0, 0, 1, 1, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
